// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the memory-bus arbiter slice:
//            the bus-owner state encoding, default bus widths, master
//            indices and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  localparam int unsigned MASTER_CPU = 0;
  localparam int unsigned MASTER_DMA = 1;

  // Owner granted in the previous cycle; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_OWN   = 2'd1,
    DMA_OWN   = 2'd2,
    DMA_BURST = 2'd3
  } owner_state;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_sat_counter.sv
// ============================================================================
// Module   : arb_sat_counter
// Purpose  : Small up-counter with clear and saturation at MAX_VAL.
//            clr and inc together restart the count at 1, so the event that
//            clears the count can also be the first one counted.
// Ports    : clk   - clock
//            reset - asynchronous active-low reset
//            inc   - count one event
//            clr   - restart the count
//            count - current count value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_sat_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] SAT = WIDTH'(MAX_VAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count != SAT)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares the data-memory/peripheral bus between the CPU MEM stage
//            (M0) and a DMA/boot-loader engine (M1). Grants are combinational
//            from the owner state and the requests; the access and any read
//            data complete in the grant cycle. DMA may lock bursts of up to
//            MAX_BURST beats; the CPU is stalled whenever it is denied.
// Config   : ARB_STARVE_GUARD_EN - when defined, a DMA master kept waiting
//            through STARVE_LIMIT consecutive CPU grants is forced through.
//            When undefined the CPU has strict priority outside bursts.
// Ports    : clk, reset (async, active-low)
//            cpu_req/we/addr/wdata -> cpu_gnt/rdata/rvalid/stall
//            dma_req/we/lock/addr/wdata -> dma_gnt/rdata/rvalid
//            bus_read/write/addr/wdata -> slave, bus_rdata <- slave
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              reset,
  // CPU MEM stage (M0)
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  // DMA / boot-loader (M1)
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  // Bus slave
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int unsigned BEAT_W = cnt_width(MAX_BURST);
  // beat_cnt holds the beats already granted, so the beat granted while it
  // equals MAX_BURST-1 is the last one of the burst.
  localparam logic [BEAT_W-1:0] LAST_BEAT_IDX = BEAT_W'(MAX_BURST - 1);

  if ((MAX_BURST < 2) || (STARVE_LIMIT < 1)) begin : g_bad_params
    $error("mem_bus_arbiter: MAX_BURST must be >= 2 and STARVE_LIMIT >= 1");
  end

  owner_state        state;
  owner_state        state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              burst_hold;
  logic              starve_force;
  logic              cpu_win;
  logic              dma_win;
  logic              last_beat;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign burst_hold = (state == DMA_BURST) && dma_req;
  assign cpu_win    = cpu_req && !burst_hold && !starve_force;
  assign dma_win    = dma_req && !cpu_win;
  assign last_beat  = (beat_cnt == LAST_BEAT_IDX);

  // Grants feed only outputs, so gating them with reset drops all bus
  // activity the moment reset asserts without touching the state logic.
  assign cpu_gnt = cpu_win && reset;
  assign dma_gnt = dma_win && reset;

  always_comb begin
    state_nxt = IDLE;
    if (cpu_win) begin
      state_nxt = CPU_OWN;
    end else if (dma_win) begin
      if (burst_hold) begin
        state_nxt = (dma_lock && !last_beat) ? DMA_BURST : DMA_OWN;
      end else begin
        state_nxt = dma_lock ? DMA_BURST : DMA_OWN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Beat counter: restarts at 1 on the grant that opens a burst and counts
  // every locked beat while the burst is held.
  arb_sat_counter #(
    .WIDTH   (BEAT_W),
    .MAX_VAL (MAX_BURST)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dma_win && dma_lock),
    .clr   (!burst_hold),
    .count (beat_cnt)
  );

  // --------------------------------------------------------------------------
  // Starvation guard
  // --------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = cnt_width(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;

  arb_sat_counter #(
    .WIDTH   (STARVE_W),
    .MAX_VAL (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_win && dma_req),
    .clr   (dma_win || !dma_req),
    .count (starve_cnt)
  );

  assign starve_force = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && dma_req;
`else
  assign starve_force = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Bus mux and master responses
  // --------------------------------------------------------------------------
  always_comb begin
    bus_read  = 1'b0;
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (cpu_gnt) begin
      bus_read  = !cpu_we;
      bus_write = cpu_we;
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      bus_read  = !dma_we;
      bus_write = dma_we;
      bus_addr  = dma_addr;
      bus_wdata = dma_wdata;
    end
  end

  assign cpu_rvalid = cpu_gnt && !cpu_we;
  assign dma_rvalid = dma_gnt && !dma_we;
  assign cpu_rdata  = cpu_rvalid ? bus_rdata : '0;
  assign dma_rdata  = dma_rvalid ? bus_rdata : '0;
  assign cpu_stall  = cpu_req && !cpu_gnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Directed self-checking bench for mem_bus_arbiter. Inputs change
//            1 time unit after each rising edge and outputs are sampled 1 unit
//            later, so every check sees the combinational grant of the cycle.
//            Expectations follow ARB_STARVE_GUARD_EN the same way the design
//            does.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_we, dma_lock;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          bus_read, bus_write;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (4),
    .MAX_BURST    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .bus_read   (bus_read),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_lock  = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    bus_rdata = '0;
  endtask

  // Finish the current cycle, then spend one cycle with no request (-> IDLE).
  task automatic end_test();
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset   = 1'b0;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    #2;
    checks++;
    if ({cpu_gnt, dma_gnt, bus_read, bus_write, cpu_rvalid, dma_rvalid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000",
               {cpu_gnt, dma_gnt, bus_read, bus_write, cpu_rvalid, dma_rvalid});
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", dut.state, IDLE);
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    cpu_addr  = 32'h0000_0ABC;
    cpu_wdata = 32'h0000_1234;
    #1;
    checks++;
    if ({bus_read, bus_write, bus_addr, bus_wdata} !== '0) begin
      errors++;
      $display("FAIL idle_bus got r%b w%b a%h d%h exp all zero",
               bus_read, bus_write, bus_addr, bus_wdata);
    end
    end_test();
  endtask

  task automatic test_cpu_read();
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h4000_0010;
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({cpu_gnt, cpu_rvalid, bus_read, bus_write, cpu_stall, dma_gnt} !== 6'b111000) begin
      errors++;
      $display("FAIL cpu_read_ctrl got %b exp 111000",
               {cpu_gnt, cpu_rvalid, bus_read, bus_write, cpu_stall, dma_gnt});
    end
    checks++;
    if (cpu_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_read_data got %h exp deadbeef", cpu_rdata);
    end
    checks++;
    if (bus_addr !== 32'h4000_0010) begin
      errors++;
      $display("FAIL cpu_read_addr got %h exp 40000010", bus_addr);
    end
    checks++;
    if (dma_rdata !== '0) begin
      errors++;
      $display("FAIL cpu_read_dma_rdata got %h exp 0", dma_rdata);
    end
    end_test();
  endtask

  task automatic test_starvation();
    cpu_req   = 1'b1;
    cpu_addr  = 32'h0000_0100;
    dma_req   = 1'b1;
    dma_addr  = 32'h0000_0200;
    bus_rdata = 32'h0000_55AA;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b100 || bus_addr !== 32'h100) begin
        errors++;
        $display("FAIL starve_cpu_win[%0d] got gnt/stall %b addr %h exp 100 addr 00000100",
                 i, {cpu_gnt, dma_gnt, cpu_stall}, bus_addr);
      end
      next_cycle();
    end
`ifdef ARB_STARVE_GUARD_EN
    #1;
    checks++;
    if ({cpu_gnt, dma_gnt, cpu_stall} !== 3'b011) begin
      errors++;
      $display("FAIL starve_forced_dma got %b exp 011", {cpu_gnt, dma_gnt, cpu_stall});
    end
    checks++;
    if (dma_rdata !== 32'h55AA || cpu_rdata !== '0) begin
      errors++;
      $display("FAIL starve_rdata got dma %h cpu %h exp 000055aa 0", dma_rdata, cpu_rdata);
    end
    next_cycle();
    #1;
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL starve_cpu_back got %b exp 10", {cpu_gnt, dma_gnt});
    end
`else
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({cpu_gnt, dma_gnt} !== 2'b10) begin
        errors++;
        $display("FAIL strict_prio[%0d] got %b exp 10", i, {cpu_gnt, dma_gnt});
      end
      next_cycle();
    end
`endif
    end_test();
  endtask

  // Locked burst from IDLE, CPU joins at beat 2; shared by the burst and
  // post-reset scenarios so both prove an 8-beat burst counted from 1.
  task automatic run_burst_with_cpu(input string tag);
    logic [2:0] exp;
    for (int b = 1; b <= 9; b++) begin
      cpu_req = (b >= 2);
      #1;
      exp = (b <= 8) ? {1'b0, 1'b1, (b >= 2)} : 3'b100;
      checks++;
      if ({cpu_gnt, dma_gnt, cpu_stall} !== exp) begin
        errors++;
        $display("FAIL %s_beat%0d got gnt/stall %b exp %b", tag, b,
                 {cpu_gnt, dma_gnt, cpu_stall}, exp);
      end
      if (b == 2) begin
        checks++;
        if (dut.beat_cnt !== 4'd1) begin
          errors++;
          $display("FAIL %s_beat_cnt got %0d exp 1", tag, dut.beat_cnt);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_burst();
    dma_req   = 1'b1;
    dma_lock  = 1'b1;
    dma_we    = 1'b0;
    dma_addr  = 32'h0000_0300;
    cpu_addr  = 32'h0000_0104;
    bus_rdata = 32'hCAFE_0000;
    #1;
    checks++;
    if (dma_rdata !== 32'hCAFE_0000 || dma_rvalid !== 1'b1 || bus_addr !== 32'h300) begin
      errors++;
      $display("FAIL burst_first_read got rdata %h rvalid %b addr %h exp cafe0000 1 00000300",
               dma_rdata, dma_rvalid, bus_addr);
    end
    run_burst_with_cpu("burst");
    // Beat 10: CPU withdrew, DMA picks the bus back up.
    cpu_req = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL burst_beat10 got %b exp 01", {cpu_gnt, dma_gnt});
    end
    end_test();
  endtask

  task automatic test_lock_drop();
    logic [2:0] exp_seq [4];
    exp_seq = '{3'b010, 3'b011, 3'b011, 3'b100};
    dma_req  = 1'b1;
    dma_lock = 1'b1;
    dma_addr = 32'h0000_0500;
    for (int c = 0; c < 4; c++) begin
      cpu_req  = (c >= 1);
      // Lock is released on the third beat, which closes the burst.
      dma_lock = (c < 2);
      #1;
      checks++;
      if ({cpu_gnt, dma_gnt, cpu_stall} !== exp_seq[c]) begin
        errors++;
        $display("FAIL lock_drop_cycle%0d got %b exp %b", c + 1,
                 {cpu_gnt, dma_gnt, cpu_stall}, exp_seq[c]);
      end
      next_cycle();
    end
    checks++;
    if (dut.state !== CPU_OWN) begin
      errors++;
      $display("FAIL lock_drop_state got %0d exp %0d", dut.state, CPU_OWN);
    end
    end_test();
  endtask

  task automatic test_reset_mid_burst();
    dma_req   = 1'b1;
    dma_lock  = 1'b1;
    dma_addr  = 32'h0000_0600;
    bus_rdata = 32'h0BAD_F00D;
    for (int b = 1; b <= 5; b++) begin
      #1;
      checks++;
      if (dma_gnt !== 1'b1) begin
        errors++;
        $display("FAIL rst_burst_beat%0d got %b exp 1", b, dma_gnt);
      end
      if (b < 5) next_cycle();
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, dma_gnt, bus_read, bus_write, dma_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_burst_outputs got %b exp 00000",
               {cpu_gnt, dma_gnt, bus_read, bus_write, dma_rvalid});
    end
    dma_req  = 1'b0;
    dma_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    dma_req  = 1'b1;
    dma_lock = 1'b1;
    run_burst_with_cpu("post_rst");
    end_test();
  endtask

  task automatic test_write_conflict();
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_0020;
    cpu_wdata = 32'h1234_5678;
    dma_req   = 1'b1;
    dma_we    = 1'b0;
    dma_addr  = 32'h0000_0400;
    bus_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({cpu_gnt, dma_gnt, bus_write, bus_read, cpu_rvalid, dma_rvalid, cpu_stall} !== 7'b1010000) begin
      errors++;
      $display("FAIL wr_conflict_ctrl got %b exp 1010000",
               {cpu_gnt, dma_gnt, bus_write, bus_read, cpu_rvalid, dma_rvalid, cpu_stall});
    end
    checks++;
    if (bus_wdata !== 32'h1234_5678 || bus_addr !== 32'h20) begin
      errors++;
      $display("FAIL wr_conflict_bus got d %h a %h exp 12345678 00000020", bus_wdata, bus_addr);
    end
    checks++;
    if (cpu_rdata !== '0 || dma_rdata !== '0) begin
      errors++;
      $display("FAIL wr_conflict_rdata got cpu %h dma %h exp 0 0", cpu_rdata, dma_rdata);
    end
    // Keep both masters contending and watch the exclusivity invariants.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      #1;
      checks++;
      if ((cpu_gnt && dma_gnt) || (bus_read && bus_write) || !(cpu_gnt || dma_gnt)) begin
        errors++;
        $display("FAIL wr_conflict_invariant[%0d] got gnt %b%b strobes %b%b exp one grant one strobe",
                 i, cpu_gnt, dma_gnt, bus_read, bus_write);
      end
    end
    end_test();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_starvation();
    test_burst();
    test_lock_drop();
    test_reset_mid_burst();
    test_write_conflict();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
